data_mem_initiator: RTL

Byte-serial load/store initiator sitting between the datapath's memory stage and the 256-byte little-endian data memory. It accepts one load or store request per handshake, walks the 1, 2 or 4 bytes of the access one per cycle over the memory's byte port (MemRead/MemWrite strobes), assembles and sign- or zero-extends load data, and returns a single-cycle response. Misaligned accesses are legal. Out-of-range addresses and the reserved size encoding return an error without touching memory.

---
 rtl/data_mem_pkg.sv | 31 +++
 rtl/load_extend.sv | 22 ++
 rtl/data_mem_initiator.sv | 113 +++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-serial data memory initiator: access sizes, FSM states, memory size.
// Pure definitions; no logic, no latency, no flow control.
package data_mem_pkg;

  localparam int ADDR_LIMIT_DEFAULT = 256;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The reserved size maps to 4 so the range check stays well defined; it errors anyway.
  function automatic logic [2:0] sizeBytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byteLane(input logic [31:0] data, input logic [1:0] lane);
    return data[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero-extends a little-endian assembled load value to 32 bits by access size.
// Combinational, zero latency; no flow control. Reserved size yields 0.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (size)
      SIZE_BYTE: result = {{24{isSigned & data[7]}}, data[7:0]};
      SIZE_HALF: result = {{16{isSigned & data[15]}}, data[15:0]};
      SIZE_WORD: result = data;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_initiator.sv
// Byte-serial load/store initiator: walks 1/2/4 bytes over the memory byte port, responds one cycle later.
// Latency N+1 cycles after accept (1 on error); reqReady only in IDLE, so requests stall during ACCESS/RESP.
module data_mem_initiator
  import data_mem_pkg::*;
#(
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAddress,
  output logic [7:0]  memWriteData,
  input  logic [7:0]  memReadData,
  output logic        MemRead,
  output logic        MemWrite
);

  state_t      state;
  logic        writeReg;
  logic        signedReg;
  logic        errReg;
  logic [1:0]  sizeReg;
  logic [1:0]  idx;
  logic [1:0]  lastIdx;
  logic [31:0] baseReg;
  logic [31:0] dataReg;

  logic [2:0]  reqBytes;
  logic [32:0] reqEnd;
  logic        reqErr;
  logic        accessing;
  logic [31:0] extData;

  // 33-bit end address so 0xFFFFFFFF + n cannot wrap back into range.
  assign reqBytes = sizeBytes(reqSize);
  assign reqEnd   = {1'b0, reqAddress} + {30'b0, reqBytes};
  assign reqErr   = (reqSize == SIZE_RSVD) || (reqEnd > 33'(ADDR_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      writeReg  <= 1'b0;
      signedReg <= 1'b0;
      errReg    <= 1'b0;
      sizeReg   <= SIZE_BYTE;
      idx       <= '0;
      lastIdx   <= '0;
      baseReg   <= '0;
      dataReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            writeReg  <= reqWrite;
            signedReg <= reqSigned;
            sizeReg   <= reqSize;
            baseReg   <= reqAddress;
            dataReg   <= reqWrite ? reqData : 32'b0;
            idx       <= '0;
            lastIdx   <= 2'(reqBytes - 3'd1);
            errReg    <= reqErr;
            state     <= reqErr ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!writeReg) begin
            dataReg[{idx, 3'b000} +: 8] <= memReadData;
          end
          idx <= idx + 2'd1;
          if (idx == lastIdx) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode from registered state so reset drops them without waiting for a clock.
  assign accessing    = (state == ACCESS);
  assign MemWrite     = accessing && writeReg;
  assign MemRead      = accessing && !writeReg;
  assign memAddress   = accessing ? (baseReg + {30'b0, idx}) : 32'b0;
  assign memWriteData = MemWrite ? byteLane(dataReg, idx) : 8'b0;

  assign reqReady  = (state == IDLE);
  assign respValid = (state == RESP);
  assign respError = respValid && errReg;

  load_extend uExtend (
    .data     (dataReg),
    .size     (sizeReg),
    .isSigned (signedReg),
    .result   (extData)
  );

  assign respData = (respValid && !writeReg && !errReg) ? extData : 32'b0;

endmodule
